// File: rtl/id_ex_operand_stage_pkg.sv
// Shared ALU opcodes and register constants for the ID/EX operand stage and its neighbours.
package id_ex_operand_stage_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'b0000;
    localparam logic [3:0] ALUOP_SUB  = 4'b0001;
    localparam logic [3:0] ALUOP_AND  = 4'b0010;
    localparam logic [3:0] ALUOP_OR   = 4'b0011;
    localparam logic [3:0] ALUOP_NOR  = 4'b0100;
    localparam logic [3:0] ALUOP_XOR  = 4'b0101;
    localparam logic [3:0] ALUOP_SLT  = 4'b0110;
    localparam logic [3:0] ALUOP_SGT  = 4'b0111;
    localparam logic [3:0] ALUOP_NAND = 4'b1101;
    localparam logic [3:0] ALUOP_XNOR = 4'b1110;
    localparam logic [3:0] ALUOP_NOP  = 4'b1111;

    localparam logic [4:0] REG_ZERO   = 5'd0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB beats register-file data; r0 never forwarded.
module fwd_mux #(
    parameter int size       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] idx,
    input  logic [size-1:0]       rf_data,
    input  logic                  exmem_we,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [size-1:0]       exmem_data,
    input  logic                  memwb_we,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [size-1:0]       memwb_data,
    output logic [size-1:0]       data
);

    // Priority select of the youngest in-flight producer of idx
    always_comb begin
        data = rf_data;
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == idx)) begin
            data = exmem_data;
        end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == idx)) begin
            data = memwb_data;
        end else begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, back-pressure hold and operand forwarding.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int size       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  id_valid,
    output logic                  id_stall,
    input  logic                  id_flush,
    input  logic [3:0]            id_AluOp,
    input  logic                  id_AluSrc,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [size-1:0]       id_rs_data,
    input  logic [size-1:0]       id_rt_data,
    input  logic [size-1:0]       id_imm,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  exmem_RegWrite,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [size-1:0]       exmem_result,
    input  logic                  memwb_RegWrite,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [size-1:0]       memwb_result,
    input  logic                  mem_ready,
    output logic                  ex_valid,
    output logic [3:0]            AluOp_EX,
    output logic [size-1:0]       ALU_A,
    output logic [size-1:0]       ALU_B,
    output logic [size-1:0]       ex_rt_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead
);

    logic                  valid_q,    valid_d;
    logic [3:0]            aluop_q,    aluop_d;
    logic                  alusrc_q,   alusrc_d;
    logic [REG_ADDR_W-1:0] rs_q,       rs_d;
    logic [REG_ADDR_W-1:0] rt_q,       rt_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic [size-1:0]       rs_data_q,  rs_data_d;
    logic [size-1:0]       rt_data_q,  rt_data_d;
    logic [size-1:0]       imm_q,      imm_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memread_q,  memread_d;

    logic                  hz_s;
    logic [size-1:0]       fwd_rs_s;
    logic [size-1:0]       fwd_rt_s;

    // A load in EX cannot feed the instruction in ID without one bubble
    always_comb begin
        hz_s = valid_q && memread_q && (rd_q != '0) && id_valid &&
               ((rd_q == id_rs) || ((rd_q == id_rt) && !id_AluSrc));
        id_stall = hz_s || !mem_ready;
    end

    // Next-state: hold on back-pressure, else bubble or capture
    always_comb begin
        valid_d    = valid_q;
        aluop_d    = aluop_q;
        alusrc_d   = alusrc_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        if (!mem_ready) begin
            valid_d = valid_q;
        end else if (id_flush || hz_s || !id_valid) begin
            valid_d    = 1'b0;
            aluop_d    = ALUOP_NOP;
            alusrc_d   = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else begin
            valid_d    = 1'b1;
            aluop_d    = id_AluOp;
            alusrc_d   = id_AluSrc;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            regwrite_d = id_RegWrite;
            memread_d  = id_MemRead;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            valid_q    <= 1'b0;
            aluop_q    <= ALUOP_NOP;
            alusrc_q   <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            aluop_q    <= aluop_d;
            alusrc_q   <= alusrc_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
        end
    end

    fwd_mux #(.size(size), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .idx        (rs_q),
        .rf_data    (rs_data_q),
        .exmem_we   (exmem_RegWrite),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_result),
        .memwb_we   (memwb_RegWrite),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_result),
        .data       (fwd_rs_s)
    );

    fwd_mux #(.size(size), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .idx        (rt_q),
        .rf_data    (rt_data_q),
        .exmem_we   (exmem_RegWrite),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_result),
        .memwb_we   (memwb_RegWrite),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_result),
        .data       (fwd_rt_s)
    );

    assign ex_valid    = valid_q;
    assign AluOp_EX    = aluop_q;
    assign ALU_A       = fwd_rs_s;
    assign ALU_B       = alusrc_q ? imm_q : fwd_rt_s;
    assign ex_rt_data  = fwd_rt_s;
    assign ex_rd       = rd_q;
    assign ex_RegWrite = regwrite_q && valid_q;
    assign ex_MemRead  = memread_q && valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus randomized bench for id_ex_operand_stage against a behavioural EX-stage model.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        Reset;
    logic        id_valid, id_flush, id_AluSrc, id_RegWrite, id_MemRead;
    logic [3:0]  id_AluOp;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exmem_RegWrite, memwb_RegWrite, mem_ready;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        id_stall, ex_valid, ex_RegWrite, ex_MemRead;
    logic [3:0]  AluOp_EX;
    logic [31:0] ALU_A, ALU_B, ex_rt_data;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic        src;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic        rw, mr;
    } ex_t;
    ex_t m;

    id_ex_operand_stage dut (
        .clk(clk), .Reset(Reset), .id_valid(id_valid), .id_stall(id_stall), .id_flush(id_flush),
        .id_AluOp(id_AluOp), .id_AluSrc(id_AluSrc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .mem_ready(mem_ready), .ex_valid(ex_valid), .AluOp_EX(AluOp_EX), .ALU_A(ALU_A),
        .ALU_B(ALU_B), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_bubble();
        m = '{default: '0};
        m.op = 4'b1111;
    endfunction

    // Youngest matching producer among in-flight results, r0 excluded
    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf);
        logic        we  [2];
        logic [4:0]  rd  [2];
        logic [31:0] val [2];
        we[0] = exmem_RegWrite; rd[0] = exmem_rd; val[0] = exmem_result;
        we[1] = memwb_RegWrite; rd[1] = memwb_rd; val[1] = memwb_result;
        for (int i = 0; i < 2; i++) begin
            if (we[i] && idx != 5'd0 && rd[i] == idx) return val[i];
        end
        return rf;
    endfunction

    function automatic logic m_hz();
        return m.valid && m.mr && m.rd != 5'd0 && id_valid &&
               (m.rd == id_rs || (m.rd == id_rt && !id_AluSrc));
    endfunction

    function automatic void m_edge();
        if (!mem_ready) begin
            // back-pressure: EX contents unchanged
        end else if (id_flush || m_hz() || !id_valid) begin
            m_bubble();
        end else begin
            m.valid = 1'b1;     m.op  = id_AluOp;   m.src = id_AluSrc;
            m.rs  = id_rs;      m.rt  = id_rt;      m.rd  = id_rd;
            m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
            m.rw  = id_RegWrite; m.mr = id_MemRead;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] fa, fb;
        fa = m_fwd(m.rs, m.rsd);
        fb = m_fwd(m.rt, m.rtd);
        chk({tag, "/ex_valid"},    {31'd0, ex_valid},    {31'd0, m.valid});
        chk({tag, "/AluOp_EX"},    {28'd0, AluOp_EX},    {28'd0, m.op});
        chk({tag, "/ex_rd"},       {27'd0, ex_rd},       {27'd0, m.rd});
        chk({tag, "/ex_RegWrite"}, {31'd0, ex_RegWrite}, {31'd0, m.valid & m.rw});
        chk({tag, "/ex_MemRead"},  {31'd0, ex_MemRead},  {31'd0, m.valid & m.mr});
        chk({tag, "/ALU_A"},       ALU_A,                fa);
        chk({tag, "/ALU_B"},       ALU_B,                m.src ? m.imm : fb);
        chk({tag, "/ex_rt_data"},  ex_rt_data,           fb);
        chk({tag, "/id_stall"},    {31'd0, id_stall},    {31'd0, m_hz() | !mem_ready});
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic src,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic rw, input logic mr);
        id_valid = v; id_AluOp = op; id_AluSrc = src; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_RegWrite = rw; id_MemRead = mr;
    endtask

    task automatic fwd_off();
        exmem_RegWrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_RegWrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    initial begin
        Reset = 1'b0;
        id_flush = 1'b0;
        mem_ready = 1'b1;
        set_id(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        fwd_off();
        m_bubble();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset/AluOp_nop", {28'd0, AluOp_EX}, 32'h0000000F);
        Reset = 1'b1;

        // ADD r3 = r1 + r2, rs forwarded from EX/MEM
        set_id(1'b1, 4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        exmem_RegWrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd100;
        #1;
        check_all("add_fwd");
        chk("add_fwd/A100", ALU_A, 32'd100);
        chk("add_fwd/B7",   ALU_B, 32'd7);

        // Both sources match rs: EX/MEM wins
        exmem_result = 32'hA;
        memwb_RegWrite = 1'b1; memwb_rd = 5'd1; memwb_result = 32'hB;
        #1;
        check_all("both_match");
        chk("both_match/A", ALU_A, 32'hA);
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        check_all("rd_zero");
        chk("rd_zero/A", ALU_A, 32'd5);
        fwd_off();

        // Load-use: LW r4 then consumer of r4
        @(negedge clk);
        set_id(1'b1, 4'b0000, 1'b1, 5'd2, 5'd0, 5'd4, 32'd8, 32'd0, 32'd16, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'b0001, 1'b0, 5'd4, 5'd6, 5'd7, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
        #1;
        check_all("lu_stall");
        chk("lu_stall/stall", {31'd0, id_stall}, 32'd1);
        tick();
        check_all("lu_bubble");
        chk("lu_bubble/valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble/op",    {28'd0, AluOp_EX}, 32'hF);
        chk("lu_bubble/stall", {31'd0, id_stall}, 32'd0);
        memwb_RegWrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h1234;
        tick();
        check_all("lu_dep");
        chk("lu_dep/A", ALU_A, 32'h1234);
        fwd_off();

        // ADDI with imm=-1 held under back-pressure
        set_id(1'b1, 4'b0000, 1'b1, 5'd5, 5'd9, 5'd9, 32'd3, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 4'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
            #1;
            check_all("hold");
            chk("hold/B",     ALU_B, 32'hFFFFFFFF);
            chk("hold/stall", {31'd0, id_stall}, 32'd1);
            chk("hold/valid", {31'd0, ex_valid}, 32'd1);
            tick();
        end
        mem_ready = 1'b1;

        // Flush kills the captured instruction; flush under back-pressure holds
        set_id(1'b1, 4'b0010, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
        id_flush = 1'b1;
        tick();
        check_all("flush");
        chk("flush/valid", {31'd0, ex_valid}, 32'd0);
        id_flush = 1'b0;
        tick();
        id_flush = 1'b1; mem_ready = 1'b0;
        tick();
        check_all("flush_hold");
        chk("flush_hold/valid", {31'd0, ex_valid}, 32'd1);
        chk("flush_hold/op",    {28'd0, AluOp_EX}, 32'h2);
        id_flush = 1'b0; mem_ready = 1'b1;

        // Randomized traffic over a small register window to provoke hazards and forwarding
        for (int i = 0; i < 400; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom_range(0, 2) == 0));
            id_flush = ($urandom_range(0, 9) == 0);
            mem_ready = ($urandom_range(0, 4) != 0);
            exmem_RegWrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_RegWrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
            #1;
            check_all("rand");
            tick();
        end

        // Reset asserted mid-cycle during a stall clears EX at once
        set_id(1'b1, 4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
        id_flush = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #2;
        Reset = 1'b0;
        m_bubble();
        #1;
        check_all("midreset");
        chk("midreset/valid", {31'd0, ex_valid},    32'd0);
        chk("midreset/op",    {28'd0, AluOp_EX},    32'hF);
        chk("midreset/rw",    {31'd0, ex_RegWrite}, 32'd0);
        chk("midreset/stall", {31'd0, id_stall},    32'd1);
        mem_ready = 1'b1;
        #1;
        chk("midreset/stall_rdy", {31'd0, id_stall}, 32'd0);
        @(negedge clk);
        Reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
